// File: rtl/term_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// term_cursor_ctrl
//
// Cursor and screen-buffer controller for the terminal text path. It sits
// behind the escape-sequence command decoder. It owns the cursor position and
// the saved-cursor register. It sequences every character RAM write:
//   - single printable characters,
//   - backspace erase,
//   - multi-cycle space fills for screen clear (Clear/ED) and line clear (EL).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   char_valid   char_in carries a character this cycle
//   char_in      ASCII character
//   Delete, CUF, CUB, CNL, CPL, CHA, CUP, ED, EL, SCP, RCP, Clear
//                one-cycle command pulses, at most one high per cycle
//   busy         fill in progress; all inputs are ignored while high
//   cur_col      cursor column
//   cur_row      cursor row
//   mem_we       character RAM write strobe (registered)
//   mem_addr     write address, row*COLS+col (registered)
//   mem_data     write data (registered)
// ---------------------------------------------------------------------------
module term_cursor_ctrl #(
   parameter int COLS = 80,
   parameter int ROWS = 30,
   parameter int AW   = $clog2(COLS*ROWS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      char_valid,
   input  logic [7:0]                char_in,
   input  logic                      Delete,
   input  logic                      CUF,
   input  logic                      CUB,
   input  logic                      CNL,
   input  logic                      CPL,
   input  logic                      CHA,
   input  logic                      CUP,
   input  logic                      ED,
   input  logic                      EL,
   input  logic                      SCP,
   input  logic                      RCP,
   input  logic                      Clear,
   output logic                      busy,
   output logic [$clog2(COLS)-1:0]   cur_col,
   output logic [$clog2(ROWS)-1:0]   cur_row,
   output logic                      mem_we,
   output logic [AW-1:0]             mem_addr,
   output logic [7:0]                mem_data
);

   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(COLS*ROWS - 1);

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   typedef enum logic {IDLE, FILL} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col_nxt;
   logic [RW-1:0]   row_nxt;
   logic [CW-1:0]   save_col, save_col_nxt;
   logic [RW-1:0]   save_row, save_row_nxt;
   logic            we_nxt;
   logic [AW-1:0]   addr_nxt;
   logic [7:0]      data_nxt;
   logic [AW-1:0]   fill_last, fill_last_nxt;  // address of the final fill write
   logic            fill_home, fill_home_nxt;  // home the cursor when the fill ends

   logic [AW-1:0]   pos_addr;   // linear address of the cursor
   logic [AW-1:0]   line_end;   // last address of the cursor row
   logic [RW-1:0]   row_inc;    // row + 1 with wrap to 0

   assign pos_addr = AW'(cur_row) * AW'(COLS) + AW'(cur_col);
   assign line_end = AW'(cur_row) * AW'(COLS) + AW'(COLS - 1);
   assign row_inc  = (cur_row == ROW_MAX) ? '0 : cur_row + RW'(1);

   assign busy = (state == FILL);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      col_nxt       = cur_col;
      row_nxt       = cur_row;
      save_col_nxt  = save_col;
      save_row_nxt  = save_row;
      we_nxt        = 1'b0;
      addr_nxt      = mem_addr;
      data_nxt      = mem_data;
      fill_last_nxt = fill_last;
      fill_home_nxt = fill_home;

      case (state)
         IDLE: begin
            // Commands outrank a character arriving in the same cycle; that
            // character is simply dropped.
            if (Clear || ED) begin
               state_nxt     = FILL;
               we_nxt        = 1'b1;
               addr_nxt      = '0;
               data_nxt      = CH_SPACE;
               fill_last_nxt = LAST_ADDR;
               fill_home_nxt = 1'b1;
            end else if (EL) begin
               // The cursor address never exceeds the row end, so the fill
               // counter stays within the screen.
               state_nxt     = FILL;
               we_nxt        = 1'b1;
               addr_nxt      = pos_addr;
               data_nxt      = CH_SPACE;
               fill_last_nxt = line_end;
               fill_home_nxt = 1'b0;
            end else if (CUF) begin
               if (cur_col != COL_MAX) col_nxt = cur_col + CW'(1);
            end else if (CUB) begin
               if (cur_col != '0) col_nxt = cur_col - CW'(1);
            end else if (CNL) begin
               if (cur_row != ROW_MAX) row_nxt = cur_row + RW'(1);
               col_nxt = '0;
            end else if (CPL) begin
               if (cur_row != '0) row_nxt = cur_row - RW'(1);
               col_nxt = '0;
            end else if (CHA) begin
               col_nxt = '0;
            end else if (CUP) begin
               col_nxt = '0;
               row_nxt = '0;
            end else if (SCP) begin
               save_col_nxt = cur_col;
               save_row_nxt = cur_row;
            end else if (RCP) begin
               col_nxt = save_col;
               row_nxt = save_row;
            end else if (Delete) begin
               // Erase the cell left of the cursor; nothing happens at col 0.
               if (cur_col != '0) begin
                  col_nxt  = cur_col - CW'(1);
                  we_nxt   = 1'b1;
                  addr_nxt = pos_addr - AW'(1);
                  data_nxt = CH_SPACE;
               end
            end else if (char_valid) begin
               if (char_in == CH_CR) begin
                  col_nxt = '0;
               end else if (char_in == CH_LF) begin
                  row_nxt = row_inc;
               end else if (char_in >= CH_SPACE && char_in <= CH_TILDE) begin
                  we_nxt   = 1'b1;
                  addr_nxt = pos_addr;
                  data_nxt = char_in;
                  // Auto-wrap to the next line; the bottom row wraps to the
                  // top because there is no scrolling.
                  if (cur_col == COL_MAX) begin
                     col_nxt = '0;
                     row_nxt = row_inc;
                  end else begin
                     col_nxt = cur_col + CW'(1);
                  end
               end
            end
         end

         FILL: begin
            // mem_addr doubles as the fill counter; the write on the bus this
            // cycle is at mem_addr, so compare it against the final address.
            we_nxt = 1'b1;
            if (mem_addr == fill_last) begin
               state_nxt = IDLE;
               we_nxt    = 1'b0;
               if (fill_home) begin
                  col_nxt = '0;
                  row_nxt = '0;
               end
            end else begin
               addr_nxt = mem_addr + AW'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cur_col   <= '0;
         cur_row   <= '0;
         save_col  <= '0;
         save_row  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_data  <= '0;
         fill_last <= '0;
         fill_home <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_col   <= col_nxt;
         cur_row   <= row_nxt;
         save_col  <= save_col_nxt;
         save_row  <= save_row_nxt;
         mem_we    <= we_nxt;
         mem_addr  <= addr_nxt;
         mem_data  <= data_nxt;
         fill_last <= fill_last_nxt;
         fill_home <= fill_home_nxt;
      end
   end

endmodule
